// File: rtl/spin_sequencer.sv
// spin_sequencer: lever conditioning, reel stop sequencing, payout and credit scoring for a three-reel slot
module spin_sequencer #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SPIN_TICKS     = 8,
  parameter int STAGGER_TICKS  = 4,
  parameter int CREDIT_W       = 4,
  parameter int START_CREDITS  = 5,
  parameter int MAX_CREDITS    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                lever,
  input  logic [3:0]          reel_msb,
  input  logic [3:0]          reel_mid,
  input  logic [3:0]          reel_lsb,
  output logic [2:0]          reel_run,
  output logic [3:0]          result_msb,
  output logic [3:0]          result_mid,
  output logic [3:0]          result_lsb,
  output logic [CREDIT_W-1:0] score,
  output logic                busy,
  output logic                win_pulse,
  output logic                result_valid,
  output logic                no_credit
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int CMAX = SPIN_TICKS > STAGGER_TICKS ? SPIN_TICKS : STAGGER_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = CREDIT_W + 3;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  typedef enum logic [2:0] {IDLE, SPIN, STOP1, STOP2, EVAL} state_t;
  state_t state_q, state_d;
  logic lever_s1_q, lever_s1_d, lever_s2_q, lever_s2_d, deb_q, deb_d, lever_go;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] run_q, run_d, payout;
  logic [3:0] res_msb_q, res_msb_d, res_mid_q, res_mid_d, res_lsb_q, res_lsb_d;
  logic [CREDIT_W-1:0] score_q, score_d;
  logic [SW-1:0] sum;
  logic stop;
  // Synchronize the raw lever and debounce it on divider ticks; lever_go marks a fresh pull
  always_comb begin
    lever_s1_d = lever;
    lever_s2_d = lever_s1_q;
    deb_d = deb_q;
    dcnt_d = '0;
    if (lever_s2_q != deb_q && tick) begin
      deb_d = dcnt_q == DB_LAST ? ~deb_q : deb_q;
      dcnt_d = dcnt_q == DB_LAST ? '0 : dcnt_q + 1'b1;
    end else if (lever_s2_q != deb_q) begin
      dcnt_d = dcnt_q;
    end
    lever_go = deb_d & ~deb_q;
  end
  // Payout from the three latched symbols, saturating credit update
  always_comb begin
    payout = (res_msb_q == res_mid_q && res_mid_q == res_lsb_q) ? 3'd5 :
             (res_msb_q == res_mid_q || res_mid_q == res_lsb_q || res_msb_q == res_lsb_q) ? 3'd2 : 3'd0;
    sum = SW'(score_q) + SW'(payout);
  end
  // Spin FSM: charge, run reels, stop them one by one on tick counts, then score
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    run_d = run_q;
    res_msb_d = res_msb_q;
    res_mid_d = res_mid_q;
    res_lsb_d = res_lsb_q;
    score_d = score_q;
    stop = tick && cnt_q == CW'(1);
    case (state_q)
      IDLE: if (lever_go && score_q != '0) begin
        score_d = score_q - 1'b1;
        run_d = 3'b111;
        cnt_d = CW'(SPIN_TICKS);
        state_d = SPIN;
      end
      SPIN: if (tick) begin
        cnt_d = stop ? CW'(STAGGER_TICKS) : cnt_q - 1'b1;
        res_msb_d = stop ? reel_msb : res_msb_q;
        run_d[2] = stop ? 1'b0 : run_q[2];
        state_d = stop ? STOP1 : SPIN;
      end
      STOP1: if (tick) begin
        cnt_d = stop ? CW'(STAGGER_TICKS) : cnt_q - 1'b1;
        res_mid_d = stop ? reel_mid : res_mid_q;
        run_d[1] = stop ? 1'b0 : run_q[1];
        state_d = stop ? STOP2 : STOP1;
      end
      STOP2: if (tick) begin
        cnt_d = cnt_q - 1'b1;
        res_lsb_d = stop ? reel_lsb : res_lsb_q;
        run_d[0] = stop ? 1'b0 : run_q[0];
        state_d = stop ? EVAL : STOP2;
      end
      EVAL: begin
        score_d = sum > SW'(MAX_CREDITS) ? CREDIT_W'(MAX_CREDITS) : sum[CREDIT_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lever_s1_q <= 1'b0;
      lever_s2_q <= 1'b0;
      deb_q <= 1'b0;
      dcnt_q <= '0;
      cnt_q <= '0;
      run_q <= '0;
      res_msb_q <= '0;
      res_mid_q <= '0;
      res_lsb_q <= '0;
      score_q <= CREDIT_W'(START_CREDITS);
    end else begin
      state_q <= state_d;
      lever_s1_q <= lever_s1_d;
      lever_s2_q <= lever_s2_d;
      deb_q <= deb_d;
      dcnt_q <= dcnt_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      res_msb_q <= res_msb_d;
      res_mid_q <= res_mid_d;
      res_lsb_q <= res_lsb_d;
      score_q <= score_d;
    end
  end
  assign reel_run = run_q;
  assign result_msb = res_msb_q;
  assign result_mid = res_mid_q;
  assign result_lsb = res_lsb_q;
  assign score = score_q;
  assign busy = state_q != IDLE;
  assign result_valid = state_q == EVAL;
  assign win_pulse = state_q == EVAL && payout != 3'd0;
  assign no_credit = state_q == IDLE && score_q == '0;
endmodule
